// File: rtl/libio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : libio
// Purpose  : I/O bus types, thread configuration and timer register map.
// Revision : 1.0
// ============================================================================
package libio;

   localparam int NTHREADIDMSB = 1;
   localparam int NTHREAD      = 2**(NTHREADIDMSB+1);
   localparam int IO_AWIDTH    = 20;

   localparam logic [11:0] IO_TMR_BASE_ADDR = 12'hF00;

   // Word offsets, compared against addr[7:2]
   localparam logic [5:0] IO_TMR_COUNTER = 6'h00;
   localparam logic [5:0] IO_TMR_RELOAD  = 6'h01;
   localparam logic [5:0] IO_TMR_SCALER  = 6'h02;
   localparam logic [5:0] IO_TMR_GCTRL   = 6'h03;
   localparam logic [5:0] IO_TMR_TCTRL   = 6'h04;
   localparam logic [5:0] IO_TMR_PEND    = 6'h05;

   typedef struct packed {
      logic       mask;
      logic [3:0] level;
   } tctrl_reg_type;

   typedef struct packed {
      logic [NTHREADIDMSB:0] tid;
      logic [IO_AWIDTH-1:0]  addr;
      logic [31:0]           wdata;
      logic                  rw;
      logic                  en;
      logic [3:0]            we;
      logic                  replay;
      logic                  wtid_valid;
   } io_bus_in_type;

   typedef struct packed {
      logic [3:0]  irl;
      logic [31:0] rdata;
      logic        retry;
   } io_bus_out_type;

endpackage
`default_nettype wire

// File: rtl/io_timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : io_timer_prescaler
// Purpose  : Prescaler plus global 32-bit down counter with underflow pulse.
// Revision : 1.0
// ============================================================================
module io_timer_prescaler
   import libio::*;
#(
   parameter int SCALER_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_en,
   input  logic                i_presc_load,
   input  logic [SCALER_W-1:0] i_scaler,
   input  logic [31:0]         i_reload,
   input  logic                i_cnt_we,
   input  logic [31:0]         i_cnt_wdata,
   output logic [31:0]         o_counter,
   output logic                o_underflow
);

   logic [SCALER_W-1:0] r_presc;
   logic [31:0]         r_counter;
   logic                w_tick;

   assign w_tick = i_en & (r_presc == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc   <= '0;
         r_counter <= 32'h0;
      end else begin
         if (i_presc_load)
            r_presc <= i_scaler;
         else if (i_en)
            r_presc <= w_tick ? i_scaler : r_presc - SCALER_W'(1);

         // A software write to COUNTER takes precedence over the tick
         if (i_cnt_we)
            r_counter <= i_cnt_wdata;
         else if (w_tick)
            r_counter <= (r_counter == 32'h0) ? i_reload : r_counter - 32'd1;
      end
   end

   assign o_counter   = r_counter;
   assign o_underflow = w_tick & (r_counter == 32'h0) & ~i_cnt_we;

endmodule
`default_nettype wire

// File: rtl/io_timer_irqctrl.sv
`default_nettype none
// ============================================================================
// Module   : io_timer_irqctrl
// Purpose  : I/O-bus timer and per-thread interrupt controller.
//            Optional byte enables: define IO_TIMER_BYTEWE_EN.
// Revision : 1.0
// ============================================================================
module io_timer_irqctrl
   import libio::*;
#(
   parameter logic [11:0] BASE_ADDR = IO_TMR_BASE_ADDR,
   parameter int          SCALER_W  = 16
) (
   input  logic                  gclk,
   input  logic                  rst,
   input  io_bus_in_type         bus_in,
   output io_bus_out_type        bus_out,
   input  logic                  irqack,
   input  logic [NTHREADIDMSB:0] irqack_tid
);

   localparam int TIDW = NTHREADIDMSB + 1;

   logic [IO_AWIDTH-1:0] r_addr;
   logic [TIDW-1:0]      r_tid;
   logic [31:0]          r_reload;
   logic [SCALER_W-1:0]  r_scaler;
   logic                 r_gctrl_en;
   logic [31:0]          r_rdata;

   logic [31:0]          w_counter;
   logic                 w_underflow;
   logic                 w_hit;
   logic                 w_wr;
   logic [5:0]           w_off;
   logic [31:0]          w_rval;
   logic                 w_wr_counter, w_wr_reload, w_wr_scaler;
   logic                 w_wr_gctrl, w_wr_tctrl, w_wr_pend;
   logic                 w_gctrl_wen, w_presc_load;
   logic [31:0]          w_cnt_wval, w_reload_wval;
   logic [SCALER_W-1:0]  w_scaler_wval;
   logic                 w_we0;
   logic [NTHREAD-1:0]   w_pend;
   logic [NTHREAD-1:0]   w_mask;
   logic [3:0]           w_level [NTHREAD];
   logic                 w_unused;

   assign w_off = r_addr[7:2];
   assign w_hit = (r_addr[IO_AWIDTH-1:8] == BASE_ADDR) & bus_in.en;
   assign w_wr  = w_hit & bus_in.rw & bus_in.wtid_valid & (bus_in.we != 4'h0);

   assign w_wr_counter = w_wr & (w_off == IO_TMR_COUNTER);
   assign w_wr_reload  = w_wr & (w_off == IO_TMR_RELOAD);
   assign w_wr_scaler  = w_wr & (w_off == IO_TMR_SCALER);
   assign w_wr_gctrl   = w_wr & (w_off == IO_TMR_GCTRL);
   assign w_wr_tctrl   = w_wr & (w_off == IO_TMR_TCTRL);
   assign w_wr_pend    = w_wr & (w_off == IO_TMR_PEND);

`ifdef IO_TIMER_BYTEWE_EN
   logic [31:0] w_bmask;
   assign w_bmask       = {{8{bus_in.we[3]}}, {8{bus_in.we[2]}},
                           {8{bus_in.we[1]}}, {8{bus_in.we[0]}}};
   assign w_cnt_wval    = (w_counter & ~w_bmask) | (bus_in.wdata & w_bmask);
   assign w_reload_wval = (r_reload & ~w_bmask) | (bus_in.wdata & w_bmask);
   assign w_scaler_wval = (r_scaler & ~w_bmask[SCALER_W-1:0])
                        | (bus_in.wdata[SCALER_W-1:0] & w_bmask[SCALER_W-1:0]);
   assign w_we0         = bus_in.we[0];
`else
   assign w_cnt_wval    = bus_in.wdata;
   assign w_reload_wval = bus_in.wdata;
   assign w_scaler_wval = bus_in.wdata[SCALER_W-1:0];
   assign w_we0         = 1'b1;
`endif

   assign w_gctrl_wen  = w_wr_gctrl & w_we0;
   // Enable rising edge restarts the prescaler from SCALER
   assign w_presc_load = w_gctrl_wen & bus_in.wdata[0] & ~r_gctrl_en;

   io_timer_prescaler #(.SCALER_W(SCALER_W)) u_prescaler (
      .clk         (gclk),
      .rst         (rst),
      .i_en        (r_gctrl_en),
      .i_presc_load(w_presc_load),
      .i_scaler    (r_scaler),
      .i_reload    (r_reload),
      .i_cnt_we    (w_wr_counter),
      .i_cnt_wdata (w_cnt_wval),
      .o_counter   (w_counter),
      .o_underflow (w_underflow)
   );

   always_comb begin
      w_rval = 32'h0;
      case (w_off)
         IO_TMR_COUNTER: w_rval = w_counter;
         IO_TMR_RELOAD:  w_rval = r_reload;
         IO_TMR_SCALER:  w_rval[SCALER_W-1:0] = r_scaler;
         IO_TMR_GCTRL:   w_rval[0] = r_gctrl_en;
         IO_TMR_TCTRL: begin
            w_rval[0]   = w_mask[r_tid];
            w_rval[7:4] = w_level[r_tid];
         end
         IO_TMR_PEND:    w_rval[0] = w_pend[r_tid];
         default:        w_rval = 32'h0;
      endcase
   end

   always_ff @(posedge gclk) begin
      if (rst) begin
         r_addr     <= '0;
         r_tid      <= '0;
         r_reload   <= 32'h0;
         r_scaler   <= '0;
         r_gctrl_en <= 1'b0;
         r_rdata    <= 32'h0;
      end else begin
         r_addr  <= bus_in.addr;
         r_tid   <= bus_in.tid;
         r_rdata <= (w_hit & ~bus_in.rw) ? w_rval : 32'h0;
         if (w_wr_reload) r_reload   <= w_reload_wval;
         if (w_wr_scaler) r_scaler   <= w_scaler_wval;
         if (w_gctrl_wen) r_gctrl_en <= bus_in.wdata[0];
      end
   end

   for (genvar t = 0; t < NTHREAD; t++) begin : g_thread
      tctrl_reg_type r_tctrl;
      logic          r_pend;
      logic          w_sel;
      logic          w_ack;
      logic          w_set;
      logic          w_clr;

      assign w_sel = (r_tid == TIDW'(t));
      assign w_ack = irqack & (irqack_tid == TIDW'(t));
      assign w_set = (w_underflow & r_tctrl.mask)
                   | (w_wr_pend & w_sel & w_we0 & bus_in.wdata[1]);
      assign w_clr = w_wr_pend & w_sel & w_we0 & bus_in.wdata[0];

      always_ff @(posedge gclk) begin
         if (rst) begin
            r_tctrl <= '0;
            r_pend  <= 1'b0;
         end else begin
            if (w_wr_tctrl & w_sel & w_we0) begin
               r_tctrl.mask  <= bus_in.wdata[0];
               r_tctrl.level <= bus_in.wdata[7:4];
            end
            // New events beat acknowledges, acknowledges beat software W1C
            if (w_set)
               r_pend <= 1'b1;
            else if (w_ack | w_clr)
               r_pend <= 1'b0;
         end
      end

      assign w_pend[t]  = r_pend;
      assign w_mask[t]  = r_tctrl.mask;
      assign w_level[t] = r_tctrl.level;
   end

   always_comb begin
      bus_out       = '0;
      bus_out.rdata = r_rdata;
      bus_out.retry = 1'b0;
      if (w_pend[bus_in.tid] & w_mask[bus_in.tid])
         bus_out.irl = w_level[bus_in.tid];
   end

   assign w_unused = ^{bus_in.replay, r_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_io_timer_irqctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_timer_irqctrl
// Purpose  : Scoreboard bench for the I/O timer / interrupt controller.
// Revision : 1.0
// ============================================================================
module tb_io_timer_irqctrl;
   import libio::*;

   localparam logic [IO_AWIDTH-1:0] c_a_cnt = 20'hF0000;
   localparam logic [IO_AWIDTH-1:0] c_a_rld = 20'hF0004;
   localparam logic [IO_AWIDTH-1:0] c_a_scl = 20'hF0008;
   localparam logic [IO_AWIDTH-1:0] c_a_gct = 20'hF000C;
   localparam logic [IO_AWIDTH-1:0] c_a_tct = 20'hF0010;
   localparam logic [IO_AWIDTH-1:0] c_a_pnd = 20'hF0014;

   logic                  gclk;
   logic                  rst;
   io_bus_in_type         bus_in;
   io_bus_out_type        bus_out;
   logic                  irqack;
   logic [NTHREADIDMSB:0] irqack_tid;

   int                    n_checks = 0;
   int                    n_fail   = 0;
   logic [31:0]           exp_q[$];
   string                 name_q[$];

   io_timer_irqctrl dut (
      .gclk      (gclk),
      .rst       (rst),
      .bus_in    (bus_in),
      .bus_out   (bus_out),
      .irqack    (irqack),
      .irqack_tid(irqack_tid)
   );

   initial gclk = 1'b0;
   always #5 gclk = ~gclk;

   // One transaction through M1, M2 and XC; optional irqack in XC
   task automatic bus_op(input logic rw, input logic [IO_AWIDTH-1:0] addr,
                         input logic [NTHREADIDMSB:0] tid, input logic [31:0] wdata,
                         input logic [3:0] we, input logic wtv, input logic rp,
                         input logic ack, input logic [31:0] exp, input string name);
      logic [31:0] want;
      string       nm;
      @(posedge gclk); #1;
      bus_in      = '0;
      bus_in.tid  = tid;
      bus_in.addr = addr;
      @(posedge gclk); #1;
      bus_in.en         = 1'b1;
      bus_in.rw         = rw;
      bus_in.wdata      = wdata;
      bus_in.we         = we;
      bus_in.wtid_valid = wtv;
      bus_in.replay     = rp;
      exp_q.push_back(rw ? 32'h0 : exp);
      name_q.push_back(name);
      @(posedge gclk); #1;
      bus_in     = '0;
      bus_in.tid = tid;
      irqack     = ack;
      irqack_tid = tid;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         want = exp_q.pop_front();
         nm   = name_q.pop_front();
         if (bus_out.rdata !== want) begin
            n_fail++;
            $display("FAIL %s: rdata got %h expected %h", nm, bus_out.rdata, want);
         end
      end
      n_checks++;
      if (bus_out.retry !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_retry: got %b expected 0", name, bus_out.retry);
      end
      @(posedge gclk); #1;
      irqack = 1'b0;
   endtask

   task automatic wr(input logic [IO_AWIDTH-1:0] addr, input logic [NTHREADIDMSB:0] tid,
                     input logic [31:0] d);
      bus_op(1'b1, addr, tid, d, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0, "wr");
   endtask

   task automatic rd(input logic [IO_AWIDTH-1:0] addr, input logic [NTHREADIDMSB:0] tid,
                     input logic [31:0] exp, input string name);
      bus_op(1'b0, addr, tid, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, exp, name);
   endtask

   task automatic check_irl(input logic [NTHREADIDMSB:0] tid, input logic [3:0] exp,
                            input string name);
      bus_in.tid = tid;
      #1;
      n_checks++;
      if (bus_out.irl !== exp) begin
         n_fail++;
         $display("FAIL %s: irl got %h expected %h", name, bus_out.irl, exp);
      end
   endtask

   task automatic test_reset();
      rst               = 1'b1;
      bus_in.en         = 1'b1;
      bus_in.rw         = 1'b1;
      bus_in.addr       = c_a_cnt;
      bus_in.tid        = 2'd3;
      bus_in.wdata      = 32'h0000FFFF;
      bus_in.we         = 4'hF;
      bus_in.wtid_valid = 1'b1;
      repeat (3) @(posedge gclk);
      #1;
      rst    = 1'b0;
      bus_in = '0;
      n_checks++;
      if (bus_out.rdata !== 32'h0 || bus_out.retry !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out: rdata %h retry %b expected 0 0", bus_out.rdata, bus_out.retry);
      end
      check_irl(2'd3, 4'h0, "reset_irl");
      rd(c_a_cnt, 2'd0, 32'h0, "reset_counter");
   endtask

   task automatic test_timer();
      logic found;
      wr(c_a_tct, 2'd3, 32'h51);
      wr(c_a_rld, 2'd3, 32'd5);
      wr(c_a_scl, 2'd3, 32'd0);
      wr(c_a_gct, 2'd3, 32'd1);
      found      = 1'b0;
      bus_in.tid = 2'd3;
      #1;
      for (int i = 0; i < 20; i++) begin
         if (bus_out.irl == 4'h5) begin
            found = 1'b1;
            break;
         end
         @(posedge gclk); #1;
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL timer_irl_tid3: irl got %h expected 5 within 20 cycles", bus_out.irl);
      end
      check_irl(2'd2, 4'h0, "timer_irl_tid2");
      rd(c_a_tct, 2'd3, 32'h51, "tctrl_rb");
      rd(c_a_pnd, 2'd3, 32'h1, "pend3_set");
      rd(c_a_gct, 2'd3, 32'h1, "gctrl_rb");
      wr(c_a_gct, 2'd3, 32'd0);
   endtask

   task automatic test_irqack();
      @(posedge gclk); #1;
      irqack = 1'b1; irqack_tid = 2'd2;
      @(posedge gclk); #1;
      irqack = 1'b0;
      check_irl(2'd3, 4'h5, "ack_other_tid");
      irqack = 1'b1; irqack_tid = 2'd3;
      @(posedge gclk); #1;
      irqack = 1'b0;
      check_irl(2'd3, 4'h0, "ack_clears");
      rd(c_a_pnd, 2'd3, 32'h0, "pend3_acked");
   endtask

   task automatic test_ack_collision();
      wr(c_a_cnt, 2'd3, 32'h100);
      rd(c_a_cnt, 2'd3, 32'h100, "counter_frozen");
      wr(c_a_cnt, 2'd3, 32'h0);
      // Enable with COUNTER=0, SCALER=0: first underflow on the edge ending XC
      bus_op(1'b1, c_a_gct, 2'd3, 32'h1, 4'hF, 1'b1, 1'b0, 1'b1, 32'h0, "gctrl_ack");
      check_irl(2'd3, 4'h5, "set_beats_ack");
      wr(c_a_gct, 2'd3, 32'd0);
      rd(c_a_pnd, 2'd3, 32'h1, "pend3_kept");
   endtask

   task automatic test_wtid_replay();
      wr(c_a_rld, 2'd0, 32'h1234);
      bus_op(1'b1, c_a_rld, 2'd0, 32'hDEAD, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0, "wr_nowtid");
      bus_op(1'b1, c_a_rld, 2'd0, 32'hBEEF, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0, "wr_we0");
      rd(c_a_rld, 2'd0, 32'h1234, "reload_kept");
      bus_op(1'b1, c_a_scl, 2'd0, 32'h7, 4'hF, 1'b1, 1'b1, 1'b0, 32'h0, "wr_replay");
      rd(c_a_scl, 2'd0, 32'h7, "scaler_replay");
      wr(c_a_scl, 2'd0, 32'h0);
   endtask

   task automatic test_miss_pend();
      rd(20'hE0000, 2'd0, 32'h0, "miss");
      rd(20'hE0004, 2'd0, 32'h0, "miss_reload_off");
      rd(20'hF0018, 2'd0, 32'h0, "unmapped");
      wr(c_a_pnd, 2'd1, 32'h2);
      rd(c_a_pnd, 2'd1, 32'h1, "pend1_force");
      wr(c_a_pnd, 2'd1, 32'h1);
      rd(c_a_pnd, 2'd1, 32'h0, "pend1_w1c");
      rd(c_a_pnd, 2'd3, 32'h1, "pend3_untouched");
   endtask

   task automatic test_bytewe();
      logic [31:0] exp;
`ifdef IO_TIMER_BYTEWE_EN
      exp = 32'hFFFF00FF;
`else
      exp = 32'h0;
`endif
      wr(c_a_rld, 2'd0, 32'hFFFFFFFF);
      bus_op(1'b1, c_a_rld, 2'd0, 32'h0, 4'b0010, 1'b1, 1'b0, 1'b0, 32'h0, "wr_byte1");
      rd(c_a_rld, 2'd0, exp, "reload_bytewe");
   endtask

   task automatic test_reset_inflight();
      wr(c_a_rld, 2'd0, 32'hA5A5);
      wr(c_a_cnt, 2'd0, 32'h77);
      @(posedge gclk); #1;
      bus_in      = '0;
      bus_in.tid  = 2'd3;
      bus_in.addr = c_a_rld;
      @(posedge gclk); #1;
      bus_in.en = 1'b1;
      bus_in.rw = 1'b0;
      rst       = 1'b1;
      @(posedge gclk); #1;
      rst        = 1'b0;
      bus_in     = '0;
      n_checks++;
      if (bus_out.rdata !== 32'h0 || bus_out.retry !== 1'b0) begin
         n_fail++;
         $display("FAIL inflight_out: rdata %h retry %b expected 0 0", bus_out.rdata, bus_out.retry);
      end
      check_irl(2'd3, 4'h0, "inflight_irl");
      rd(c_a_cnt, 2'd0, 32'h0, "inflight_counter");
      rd(c_a_rld, 2'd0, 32'h0, "inflight_reload");
      rd(c_a_tct, 2'd3, 32'h0, "inflight_tctrl");
      rd(c_a_pnd, 2'd3, 32'h0, "inflight_pend");
   endtask

   initial begin
      rst        = 1'b1;
      irqack     = 1'b0;
      irqack_tid = '0;
      bus_in     = '0;
      test_reset();
      test_timer();
      test_irqack();
      test_ack_collision();
      test_wtid_replay();
      test_miss_pend();
      test_bytewe();
      test_reset_inflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/io_timer_irqctrl.md
Name: io_timer_irqctrl

Overview:
- I/O-bus responder: one global down-counting timer plus a per-thread interrupt controller.
- Decodes CPU->IO bus requests for register reads and writes, and drives the IO->CPU bus with rdata, retry and a combinational per-thread IRL.
- Sits on the shared I/O bus beside other devices; response buses are OR-combined, so this block drives zeros when not addressed.

Parameters:
- BASE_ADDR, 12'hF00, match value for addr[IO_AWIDTH-1:8] (256-byte window).
- SCALER_W, 16, prescaler width in bits.
- NTHREAD, 2**(NTHREADIDMSB+1), number of thread contexts; taken from libconf.

Ports:
- gclk  in  1  pipeline clock.
- rst  in  1  synchronous reset, active-high.
- bus_in  in  io_bus_in_type  CPU->IO request (tid valid in M1; addr valid at end of M1; wdata/rw/en/we/replay/wtid_valid valid in M2).
- bus_out  out  io_bus_out_type  IO->CPU response (irl, rdata, retry).
- irqack  in  1  interrupt acknowledge, valid in XC.
- irqack_tid  in  NTHREADIDMSB+1  thread being acknowledged.

Behaviour:
- Clock edges: E1 ends M1, E2 ends M2.
- At E1: capture bus_in.addr and bus_in.tid into stage registers addr_r and tid_r.
- hit = (addr_r[IO_AWIDTH-1:8] == BASE_ADDR) & bus_in.en.
- Register map, word offset addr_r[7:2]:
  - 0x00 COUNTER (32b, global, R/W).
  - 0x04 RELOAD (32b, global).
  - 0x08 SCALER (SCALER_W, global reload value).
  - 0x0C GCTRL (bit0 timer enable).
  - 0x10 TCTRL[tid_r] (bit0 mask, bits7:4 level).
  - 0x14 PEND[tid_r]: read returns bit0 = pending; write bit0=1 clears; write bit1=1 forces set.
  - Other offsets read 0; writes to them are ignored.
- Read: at E2, if hit & !rw, load rdata_q with the pre-write register value. Otherwise load rdata_q with 0. rdata_q is held through XC (one-cycle latency after M2).
- Write: committed at E2 when hit & rw & wtid_valid & (we != 0). If wtid_valid=0, the write has no side effects.
- replay=1 writes commit normally; all registers are idempotent (W1C / overwrite).
- retry: always 0. This device responds with fixed latency; non-hit cycles return rdata 0, retry 0.
- irl: combinational from bus_in.tid. irl = (pend[tid] & mask[tid]) ? level[tid] : 0. level 0 therefore yields irl 0.
- Prescaler, when GCTRL.en=1:
  - Decrements every cycle.
  - At 0, reloads from SCALER and generates tick.
  - SCALER=0 gives a tick every cycle.
- Counter on tick:
  - If COUNTER==0: reload from RELOAD, set pend[t] for every t with mask[t]=1.
  - Else: decrement.
- GCTRL.en=0 freezes both the prescaler and the counter. Writing GCTRL.en 0->1 reloads the prescaler.
- COUNTER write and tick in the same cycle: the write wins.
- Same-cycle events on pend[t], priority highest first:
  1. Timer set / force.
  2. irqack clear.
  3. W1C clear.

  Timer set wins because it is a new event.
- irqack applies at the edge ending XC: pend[irqack_tid] <= 0, subject to the priority above.
- Reset mid-operation clears everything next edge:
  - In-flight stage registers and pending write are cleared.
  - All registers, pend, mask and level go to 0.
  - rdata=0, retry=0, irl=0.

Optional Feature:
- Macro IO_TIMER_BYTEWE_EN.
- Defined: we[i] gates byte i of every written register (PEND honours we[0] only).
- Undefined: any nonzero we writes the full word; byte-enable logic is omitted.

Decomposition:
- Package libio: register offset constants (IO_TMR_COUNTER … IO_TMR_PEND), the tctrl_reg_type struct {mask, level[3:0]}, and the BASE_ADDR default.
- Sub-module io_timer_prescaler holds the prescaler and counter and emits a one-cycle underflow pulse. The top level holds decode, per-thread state, and the response registers.

Test Plan:
- Reset with en=1 traffic in flight -> rdata=0, retry=0, irl=0 on the cycle after rst; COUNTER reads 0.
- tid=3: write TCTRL=0x51, RELOAD=5, SCALER=0, GCTRL=1 -> after the counter reaches 0 (≈6 cycles), pend[3]=1. Presenting tid=3 in M1 gives irl=5; tid=2 gives irl=0.
- tid=3 pending; irqack=1, irqack_tid=3 -> pend[3]=0 next cycle, irl=0. Repeat with timer underflow on the same cycle -> pend stays 1.
- Write with wtid_valid=0 to RELOAD=0x1234 -> RELOAD readback is unchanged. Read addr 20'hF0004 -> rdata 0x1234 valid in XC of the reading instruction.
- Read addr 20'hE0000 (miss) -> rdata=0, retry=0. Write PEND=0x2 then 0x1 -> pend toggles 1 then 0.
- With IO_TIMER_BYTEWE_EN: RELOAD=0xFFFFFFFF, then write 0x00000000 with we=4'b0010 -> reads 0xFFFF00FF. Without the macro -> reads 0.
